// File: rtl/ysyx_25030085_imem_pkg.sv
// ysyx_25030085_imem_pkg: shared FSM encoding and constants for the instruction-memory responder
package ysyx_25030085_imem_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;
    localparam logic [31:0] ERR_INST      = 32'h0000_0000;
    localparam logic [7:0]  LFSR_SEED     = 8'hA5;
    // taps x^8+x^6+x^5+x^4+1 as bit positions 7,5,4,3 of a left-shifting register
    localparam logic [7:0]  LFSR_TAPS     = 8'hB8;
    function automatic logic lfsr_fb(input logic [7:0] q);
        return ^(q & LFSR_TAPS);
    endfunction
endpackage

// File: rtl/ysyx_25030085_lfsr8.sv
// ysyx_25030085_lfsr8: free-running 8-bit Fibonacci LFSR, reset to the seed
module ysyx_25030085_lfsr8
    import ysyx_25030085_imem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] lfsr_o
);
    logic [7:0] lfsr_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= LFSR_SEED;
        else     lfsr_q <= {lfsr_q[6:0], lfsr_fb(lfsr_q)};
    end
    assign lfsr_o = lfsr_q;
endmodule

// File: rtl/ysyx_25030085_imem_rsp.sv
// ysyx_25030085_imem_rsp: instruction SRAM answering one fetch at a time after LATENCY (+jitter) cycles
module ysyx_25030085_imem_rsp
    import ysyx_25030085_imem_pkg::*;
#(
    parameter int          DEPTH     = 4096,
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int          LATENCY   = 1,
    parameter bit          JITTER_EN = 1'b0,
    parameter int          AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   req_addr,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_inst,
    output logic          rsp_err,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data
);
    localparam int CW = $clog2(LATENCY + 4) + 1;
    state_e        state_q;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   addr_q;
    logic [CW-1:0] cnt_q;
    logic          rsp_valid_q;
    logic          rsp_err_q;
    logic [31:0]   rsp_inst_q;
    logic [7:0]    lfsr;
    logic          unused_lfsr;
    logic [1:0]    jit;
    logic [31:0]   idx;
    logic          err;

    ysyx_25030085_lfsr8 u_lfsr (.clk(clk), .rst(rst), .lfsr_o(lfsr));

    assign unused_lfsr = ^lfsr[7:2];
    assign jit         = JITTER_EN ? lfsr[1:0] : 2'd0;
    // a below-base address wraps in the subtraction, so it is rejected on its own
    assign idx         = (addr_q - BASE_ADDR) >> 2;
    assign err         = (addr_q[1:0] != 2'd0) || (addr_q < BASE_ADDR) || (idx >= 32'(DEPTH));
    assign req_ready   = (state_q == IDLE) && !rst;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_inst    = rsp_inst_q;
    assign rsp_err     = rsp_err_q;

    always_ff @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_inst_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    addr_q  <= req_addr;
                    cnt_q   <= CW'(LATENCY - 1) + CW'(jit);
                    state_q <= WAIT;
                end
                // capture reads the array before any same-edge load lands
                WAIT: if (cnt_q == '0) begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= err;
                    rsp_inst_q  <= err ? ERR_INST : mem[idx[AW-1:0]];
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_25030085_imem_rsp.sv
// tb_ysyx_25030085_imem_rsp: directed checks over four responder configurations
module tb_ysyx_25030085_imem_rsp;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid [4];
    logic        req_ready [4];
    logic [31:0] req_addr  [4];
    logic        rsp_valid [4];
    logic        rsp_ready [4];
    logic [31:0] rsp_inst  [4];
    logic        rsp_err   [4];
    logic        load_en   [4];
    logic [11:0] load_addr [4];
    logic [31:0] load_data [4];
    logic [31:0] model     [64];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    // 0: LAT1, 1: LAT3, 2: LAT2, 3: LAT1 with jitter
    for (genvar g = 0; g < 4; g++) begin : g_dut
        ysyx_25030085_imem_rsp #(
            .LATENCY  (g == 1 ? 3 : g == 2 ? 2 : 1),
            .JITTER_EN(g == 3)
        ) u_dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_addr(req_addr[g]),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_inst(rsp_inst[g]),
            .rsp_err(rsp_err[g]),
            .load_en(load_en[g]), .load_addr(load_addr[g]), .load_data(load_data[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load(input int k, input int a, input logic [31:0] d);
        @(negedge clk);
        load_en[k] = 1'b1; load_addr[k] = 12'(a); load_data[k] = d;
        @(posedge clk); #1;
        load_en[k] = 1'b0;
    endtask

    task automatic req(input int k, input logic [31:0] a);
        @(negedge clk);
        req_addr[k] = a; req_valid[k] = 1'b1;
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
    endtask

    task automatic wait_rsp(input int k, output int lat);
        lat = 0;
        while (!rsp_valid[k] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("rsp_timeout", 32'(rsp_valid[k]), 32'd1);
    endtask

    task automatic ack(input int k, output logic [31:0] inst, output logic err);
        inst = rsp_inst[k]; err = rsp_err[k];
        rsp_ready[k] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[k] = 1'b0;
    endtask

    task automatic fetch(input int k, input logic [31:0] a, output int lat,
                         output logic [31:0] inst, output logic err);
        req(k, a);
        wait_rsp(k, lat);
        ack(k, inst, err);
    endtask

    initial begin
        int          lat;
        int          drops;
        int          i;
        logic [31:0] inst;
        logic        err;
        bit          seen [4];
        for (int k = 0; k < 4; k++) begin
            req_valid[k] = 1'b0; req_addr[k] = '0; rsp_ready[k] = 1'b0;
            load_en[k] = 1'b0; load_addr[k] = '0; load_data[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready[0]), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("rst_rsp_inst", rsp_inst[0], 32'd0);
        check("rst_rsp_err", 32'(rsp_err[0]), 32'd0);
        @(negedge clk) rst = 1'b0;
        #1 check("idle_req_ready", 32'(req_ready[0]), 32'd1);

        // basic fetches and faults, LATENCY=1
        load(0, 0, 32'h0000_0413);
        load(0, 1, 32'h0010_0073);
        load(0, 4095, 32'h1234_5678);
        fetch(0, 32'h8000_0000, lat, inst, err);
        check("f0_lat", lat, 32'd1); check("f0_inst", inst, 32'h0000_0413); check("f0_err", 32'(err), 32'd0);
        fetch(0, 32'h8000_0004, lat, inst, err);
        check("f1_lat", lat, 32'd1); check("f1_inst", inst, 32'h0010_0073); check("f1_err", 32'(err), 32'd0);
        fetch(0, 32'h8000_0002, lat, inst, err);
        check("mis_err", 32'(err), 32'd1); check("mis_inst", inst, 32'd0);
        fetch(0, 32'h7FFF_FFFC, lat, inst, err);
        check("low_err", 32'(err), 32'd1); check("low_inst", inst, 32'd0);
        fetch(0, 32'h8000_4000, lat, inst, err);
        check("top_err", 32'(err), 32'd1);
        fetch(0, 32'hFFFF_FFFC, lat, inst, err);
        check("far_err", 32'(err), 32'd1);
        fetch(0, 32'h8000_3FFC, lat, inst, err);
        check("last_err", 32'(err), 32'd0); check("last_inst", inst, 32'h1234_5678);

        // back-pressure, LATENCY=3
        load(1, 2, 32'hABCD_0001);
        req(1, 32'h8000_0008);
        check("bp_req_ready_wait", 32'(req_ready[1]), 32'd0);
        wait_rsp(1, lat);
        check("bp_lat", lat, 32'd3);
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 32'(rsp_valid[1]), 32'd1);
            check("bp_inst", rsp_inst[1], 32'hABCD_0001);
            check("bp_req_ready", 32'(req_ready[1]), 32'd0);
            @(posedge clk); #1;
        end
        ack(1, inst, err);
        check("bp_ack_inst", inst, 32'hABCD_0001);
        check("bp_valid_drop", 32'(rsp_valid[1]), 32'd0);
        check("bp_req_ready_back", 32'(req_ready[1]), 32'd1);

        // load collisions, LATENCY=2
        load(2, 5, 32'h1111_1111);
        load(2, 6, 32'h2222_2222);
        req(2, 32'h8000_0014);
        @(posedge clk); #1;
        load_en[2] = 1'b1; load_addr[2] = 12'd5; load_data[2] = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        load_en[2] = 1'b0;
        check("col_valid", 32'(rsp_valid[2]), 32'd1);
        ack(2, inst, err);
        check("col_old", inst, 32'h1111_1111);
        fetch(2, 32'h8000_0014, lat, inst, err);
        check("col_written", inst, 32'hDEAD_BEEF);
        req(2, 32'h8000_0018);
        load_en[2] = 1'b1; load_addr[2] = 12'd6; load_data[2] = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        load_en[2] = 1'b0;
        wait_rsp(2, lat);
        ack(2, inst, err);
        check("early_new", inst, 32'hDEAD_BEEF);

        // jitter, LATENCY=1 plus 0..3
        for (int w = 0; w < 64; w++) begin
            model[w] = $urandom;
            load(3, w, model[w]);
        end
        for (int n = 0; n < 4; n++) seen[n] = 1'b0;
        for (int n = 0; n < 200; n++) begin
            i = int'($urandom_range(0, 63));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            fetch(3, 32'h8000_0000 + 32'(4 * i), lat, inst, err);
            check("jit_lat_range", 32'(lat >= 1 && lat <= 4), 32'd1);
            check("jit_inst", inst, model[i]);
            if (lat >= 1 && lat <= 4) seen[lat-1] = 1'b1;
        end
        for (int n = 0; n < 4; n++) check("jit_seen", 32'(seen[n]), 32'd1);

        // asynchronous reset while waiting, LATENCY=3
        req(1, 32'h8000_0008);
        @(posedge clk); #4;
        rst = 1'b1;
        #1;
        check("ar_valid", 32'(rsp_valid[1]), 32'd0);
        check("ar_req_ready", 32'(req_ready[1]), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        drops = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rsp_valid[1]) drops++;
        end
        check("ar_no_rsp", drops, 32'd0);
        check("ar_ready", 32'(req_ready[1]), 32'd1);
        fetch(1, 32'h8000_0008, lat, inst, err);
        check("ar_lat", lat, 32'd3);
        check("ar_inst", inst, 32'hABCD_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
